spi_word_peripheral: RTL and testbench

SPI_WORD_PERIPHERAL -- requirements
Module: spi_word_peripheral

---
 rtl/spi_word_peripheral.sv | 209 ++++++++++++++++++++
 tb/tb_spi_word_peripheral.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_word_peripheral.sv
// SPI slave that moves fixed-width words between an SPI master and the i_Clk domain.
// All SPI pins are oversampled through 2-flop synchronisers; every register runs on i_Clk.
`timescale 1ns/1ps
module spi_word_peripheral #(
  parameter int SPI_MODE   = 0,
  parameter int WORD_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  output logic                  o_RX_DV,
  output logic [WORD_WIDTH-1:0] o_RX_Word,
  output logic                  o_RX_Abort,
  input  logic                  i_TX_Valid,
  input  logic [WORD_WIDTH-1:0] i_TX_Word,
  output logic                  o_TX_Ready,
  output logic                  o_TX_Underrun,
  output logic                  o_Busy,
  input  logic                  i_SPI_Clk,
  input  logic                  i_SPI_MOSI,
  input  logic                  i_SPI_CS_n,
  output logic                  o_SPI_MISO,
  output logic                  o_SPI_MISO_En
);

  localparam bit CPOL = SPI_MODE[1];
  localparam bit CPHA = SPI_MODE[0];
  localparam int CW   = $clog2(WORD_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_WIDTH - 1);

  // Synchronisers plus one delayed copy of clock and CS_n for edge detection.
  logic sclk_s1_q, sclk_s2_q, sclk_d_q;
  logic mosi_s1_q, mosi_s2_q;
  logic cs_s1_q, cs_s2_q, cs_d_q;
  logic [1:0] fill_q;

  logic                  armed_q, armed_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [WORD_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WORD_WIDTH-1:0] rx_word_q, rx_word_d;
  logic                  rx_dv_q, rx_dv_d;
  logic                  rx_abort_q, rx_abort_d;
  logic [WORD_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [WORD_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic                  miso_q, miso_d;
  logic                  underrun_q, underrun_d;
  logic                  gap_q, gap_d;

  logic rise, fall, cs_low, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise, word_load;
  logic [WORD_WIDTH-1:0] load_word;

  function automatic logic [WORD_WIDTH-1:0] tx_shift(input logic [WORD_WIDTH-1:0] w);
    return MSB_FIRST ? {w[WORD_WIDTH-2:0], 1'b0} : {1'b0, w[WORD_WIDTH-1:1]};
  endfunction

  function automatic logic first_bit(input logic [WORD_WIDTH-1:0] w);
    return MSB_FIRST ? w[WORD_WIDTH-1] : w[0];
  endfunction

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_d_q  <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_d_q    <= 1'b1;
      fill_q    <= 2'b00;
    end else begin
      sclk_s1_q <= i_SPI_Clk;
      sclk_s2_q <= sclk_s1_q;
      sclk_d_q  <= sclk_s2_q;
      mosi_s1_q <= i_SPI_MOSI;
      mosi_s2_q <= mosi_s1_q;
      cs_s1_q   <= i_SPI_CS_n;
      cs_s2_q   <= cs_s1_q;
      cs_d_q    <= cs_s2_q;
      fill_q    <= {fill_q[0], 1'b1};
    end
  end

  // armed_q only sets once the CS_n pipeline holds a genuinely sampled high level,
  // so a frame already in progress at reset release is never picked up half-way.
  always_comb begin
    rise        = sclk_s2_q & ~sclk_d_q;
    fall        = ~sclk_s2_q & sclk_d_q;
    cs_low      = armed_q & ~cs_s2_q;
    lead_edge   = cs_low & (CPOL ? fall : rise);
    trail_edge  = cs_low & (CPOL ? rise : fall);
    sample_edge = CPHA ? trail_edge : lead_edge;
    shift_edge  = CPHA ? lead_edge : trail_edge;
    cs_fall     = armed_q & cs_d_q & ~cs_s2_q;
    cs_rise     = ~cs_d_q & cs_s2_q;
    armed_d     = armed_q | (fill_q[1] & cs_s2_q);
    word_load   = cs_fall | (lead_edge & gap_q);
    load_word   = hold_full_q ? hold_q : (i_TX_Valid ? i_TX_Word : '0);
  end

  // TX handshake: a word is accepted on any cycle where i_TX_Valid and o_TX_Ready are
  // both high; o_TX_Ready is simply "holding register empty". A follow-on word is only
  // committed at the first leading edge after the previous word, so a frame ending on a
  // word boundary neither consumes the holding register nor reports an underrun.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    rx_word_d   = rx_word_q;
    rx_dv_d     = 1'b0;
    rx_abort_d  = 1'b0;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_sr_d     = tx_sr_q;
    miso_d      = miso_q;
    underrun_d  = 1'b0;
    gap_d       = gap_q;

    if (word_load) begin
      underrun_d  = ~hold_full_q & ~i_TX_Valid;
      hold_full_d = 1'b0;
      gap_d       = 1'b0;
      if (CPHA && cs_fall) begin
        tx_sr_d = load_word;
      end else begin
        tx_sr_d = tx_shift(load_word);
        miso_d  = first_bit(load_word);
      end
    end else begin
      if (i_TX_Valid && !hold_full_q) begin
        hold_d      = i_TX_Word;
        hold_full_d = 1'b1;
      end
      if (shift_edge) begin
        if (!CPHA && gap_q) begin
          miso_d = hold_full_q ? first_bit(hold_q) : 1'b0;
        end else begin
          miso_d  = first_bit(tx_sr_q);
          tx_sr_d = tx_shift(tx_sr_q);
        end
      end
    end

    if (sample_edge) begin
      rx_sr_d = MSB_FIRST ? {rx_sr_q[WORD_WIDTH-2:0], mosi_s2_q}
                          : {mosi_s2_q, rx_sr_q[WORD_WIDTH-1:1]};
      if (bit_cnt_q == LAST_BIT) begin
        rx_word_d = rx_sr_d;
        rx_dv_d   = 1'b1;
        bit_cnt_d = '0;
        gap_d     = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    if (cs_fall) begin
      bit_cnt_d = '0;
    end

    if (cs_rise) begin
      rx_abort_d = (bit_cnt_q != '0);
      bit_cnt_d  = '0;
      gap_d      = 1'b0;
      miso_d     = 1'b0;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      armed_q     <= 1'b0;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      rx_word_q   <= '0;
      rx_dv_q     <= 1'b0;
      rx_abort_q  <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_sr_q     <= '0;
      miso_q      <= 1'b0;
      underrun_q  <= 1'b0;
      gap_q       <= 1'b0;
    end else begin
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      rx_word_q   <= rx_word_d;
      rx_dv_q     <= rx_dv_d;
      rx_abort_q  <= rx_abort_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_sr_q     <= tx_sr_d;
      miso_q      <= miso_d;
      underrun_q  <= underrun_d;
      gap_q       <= gap_d;
    end
  end

  assign o_RX_DV       = rx_dv_q;
  assign o_RX_Word     = rx_word_q;
  assign o_RX_Abort    = rx_abort_q;
  assign o_TX_Ready    = ~hold_full_q;
  assign o_TX_Underrun = underrun_q;
  assign o_Busy        = cs_low;
  assign o_SPI_MISO_En = cs_low;
  assign o_SPI_MISO    = cs_low & miso_q;

endmodule

// File: tb/tb_spi_word_peripheral.sv
// Directed bench: three peripherals (mode 0/8-bit MSB, mode 3/16-bit LSB, mode 1/8-bit MSB)
// each driven by its own behavioural SPI master.
`timescale 1ns/1ps
module tb_spi_word_peripheral;

  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] sclk = 3'b010;
  logic [2:0] csn  = 3'b111;
  logic [2:0] mosi = 3'b000;
  logic [2:0] tx_valid = 3'b000;
  logic [7:0]  tx_word0 = '0, tx_word2 = '0;
  logic [15:0] tx_word1 = '0;

  logic dv0, dv1, dv2, ab0, ab1, ab2, rdy0, rdy1, rdy2, un0, un1, un2;
  logic busy0, busy1, busy2, miso0, miso1, miso2, en0, en1, en2;
  logic [7:0]  rxw0, rxw2;
  logic [15:0] rxw1;

  int checks = 0, passed = 0, failed = 0;
  int dv_cnt[3] = '{0, 0, 0};
  int ab_cnt[3] = '{0, 0, 0};
  int un_cnt[3] = '{0, 0, 0};
  int ready_low0 = 0;
  logic watch_ready0 = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] rxq1[$];

  spi_word_peripheral #(.SPI_MODE(0), .WORD_WIDTH(8), .MSB_FIRST(1'b1)) u0 (
    .i_Clk(clk), .i_Rst(rst), .o_RX_DV(dv0), .o_RX_Word(rxw0), .o_RX_Abort(ab0),
    .i_TX_Valid(tx_valid[0]), .i_TX_Word(tx_word0), .o_TX_Ready(rdy0), .o_TX_Underrun(un0),
    .o_Busy(busy0), .i_SPI_Clk(sclk[0]), .i_SPI_MOSI(mosi[0]), .i_SPI_CS_n(csn[0]),
    .o_SPI_MISO(miso0), .o_SPI_MISO_En(en0));

  spi_word_peripheral #(.SPI_MODE(3), .WORD_WIDTH(16), .MSB_FIRST(1'b0)) u1 (
    .i_Clk(clk), .i_Rst(rst), .o_RX_DV(dv1), .o_RX_Word(rxw1), .o_RX_Abort(ab1),
    .i_TX_Valid(tx_valid[1]), .i_TX_Word(tx_word1), .o_TX_Ready(rdy1), .o_TX_Underrun(un1),
    .o_Busy(busy1), .i_SPI_Clk(sclk[1]), .i_SPI_MOSI(mosi[1]), .i_SPI_CS_n(csn[1]),
    .o_SPI_MISO(miso1), .o_SPI_MISO_En(en1));

  spi_word_peripheral #(.SPI_MODE(1), .WORD_WIDTH(8), .MSB_FIRST(1'b1)) u2 (
    .i_Clk(clk), .i_Rst(rst), .o_RX_DV(dv2), .o_RX_Word(rxw2), .o_RX_Abort(ab2),
    .i_TX_Valid(tx_valid[2]), .i_TX_Word(tx_word2), .o_TX_Ready(rdy2), .o_TX_Underrun(un2),
    .o_Busy(busy2), .i_SPI_Clk(sclk[2]), .i_SPI_MOSI(mosi[2]), .i_SPI_CS_n(csn[2]),
    .o_SPI_MISO(miso2), .o_SPI_MISO_En(en2));

  // Pulse monitors, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (dv0) dv_cnt[0]++;
    if (dv1) begin dv_cnt[1]++; rxq1.push_back(rxw1); end
    if (dv2) dv_cnt[2]++;
    if (ab0) ab_cnt[0]++;
    if (ab1) ab_cnt[1]++;
    if (ab2) ab_cnt[2]++;
    if (un0) un_cnt[0]++;
    if (un1) un_cnt[1]++;
    if (un2) un_cnt[2]++;
    if (watch_ready0 && !rdy0) ready_low0++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_miso(input int inst);
    case (inst)
      0: return miso0;
      1: return miso1;
      default: return miso2;
    endcase
  endfunction

  function automatic logic get_ready(input int inst);
    case (inst)
      0: return rdy0;
      1: return rdy1;
      default: return rdy2;
    endcase
  endfunction

  task automatic tx_load(input int inst, input logic [15:0] w);
    chk("tx_ready_before_load", {31'd0, get_ready(inst)}, 32'd1);
    @(negedge clk);
    tx_valid[inst] = 1'b1;
    if (inst == 0) tx_word0 = w[7:0];
    else if (inst == 1) tx_word1 = w;
    else tx_word2 = w[7:0];
    @(posedge clk);
    #1 tx_valid[inst] = 1'b0;
    chk("tx_ready_after_load", {31'd0, get_ready(inst)}, 32'd0);
  endtask

  task automatic cs_low(input int inst);
    csn[inst] = 1'b0;
    #(HALF);
  endtask

  task automatic cs_high(input int inst);
    #(HALF);
    csn[inst] = 1'b1;
    #(2 * HALF);
  endtask

  // Behavioural master: shifts nbits of tx (of a width-bit word) and returns MISO bits.
  task automatic spi_word(input int inst, input int mode, input int width, input bit msb,
                          input int nbits, input logic [31:0] tx, output logic [31:0] rx);
    logic cpol, cpha;
    int idx;
    cpol = ((mode >> 1) & 1) != 0;
    cpha = (mode & 1) != 0;
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = msb ? (width - 1 - i) : i;
      if (!cpha) begin
        mosi[inst] = tx[idx];
        #(HALF); sclk[inst] = ~cpol;
        rx[idx] = get_miso(inst);
        #(HALF); sclk[inst] = cpol;
      end else begin
        sclk[inst] = ~cpol; mosi[inst] = tx[idx];
        #(HALF); sclk[inst] = cpol;
        rx[idx] = get_miso(inst);
        #(HALF);
      end
    end
  endtask

  logic [31:0] rxa, rxb;
  int dv_s, ab_s, un_s;

  initial begin
    // Reset values.
    repeat (4) @(posedge clk);
    #1;
    chk("rst_rx_dv", {31'd0, dv0}, 32'd0);
    chk("rst_rx_word", {24'd0, rxw0}, 32'd0);
    chk("rst_abort", {31'd0, ab0}, 32'd0);
    chk("rst_tx_ready", {31'd0, rdy0}, 32'd1);
    chk("rst_underrun", {31'd0, un0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_miso", {31'd0, miso0}, 32'd0);
    chk("rst_miso_en", {31'd0, en0}, 32'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    // Mode 0: TX 0xA5 while master sends 0x3C.
    tx_load(0, 16'h00A5);
    cs_low(0);
    spi_word(0, 0, 8, 1'b1, 8, 32'h3C, rxa);
    chk("m0_busy_in_frame", {31'd0, busy0}, 32'd1);
    chk("m0_miso_en_in_frame", {31'd0, en0}, 32'd1);
    cs_high(0);
    chk("m0_miso_word", rxa, 32'hA5);
    chk("m0_dv_count", dv_cnt[0], 32'd1);
    chk("m0_rx_word", {24'd0, rxw0}, 32'h3C);
    chk("m0_no_underrun", un_cnt[0], 32'd0);
    chk("m0_ready_after", {31'd0, rdy0}, 32'd1);
    chk("m0_miso_en_idle", {31'd0, en0}, 32'd0);

    // Underrun: empty holding register.
    dv_s = dv_cnt[0]; un_s = un_cnt[0];
    cs_low(0);
    spi_word(0, 0, 8, 1'b1, 8, 32'h96, rxa);
    cs_high(0);
    chk("ur_miso_zero", rxa, 32'h00);
    chk("ur_underrun_once", un_cnt[0] - un_s, 32'd1);
    chk("ur_dv_count", dv_cnt[0] - dv_s, 32'd1);
    chk("ur_rx_word", {24'd0, rxw0}, 32'h96);

    // Abort after 5 of 8 bits, then a full frame.
    dv_s = dv_cnt[0]; ab_s = ab_cnt[0];
    cs_low(0);
    spi_word(0, 0, 8, 1'b1, 5, 32'h5F, rxa);
    cs_high(0);
    chk("ab_abort_pulse", ab_cnt[0] - ab_s, 32'd1);
    chk("ab_no_dv", dv_cnt[0] - dv_s, 32'd0);
    chk("ab_word_held", {24'd0, rxw0}, 32'h96);
    cs_low(0);
    spi_word(0, 0, 8, 1'b1, 8, 32'hC3, rxa);
    cs_high(0);
    chk("ab_next_dv", dv_cnt[0] - dv_s, 32'd1);
    chk("ab_next_word", {24'd0, rxw0}, 32'hC3);
    chk("ab_abort_once", ab_cnt[0] - ab_s, 32'd1);

    // Mode 3, 16-bit LSB-first, two back-to-back words in one frame.
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'hBEEF);
    un_s = un_cnt[1];
    tx_load(1, 16'hA1B2);
    cs_low(1);
    spi_word(1, 3, 16, 1'b0, 16, 32'h1234, rxa);
    tx_load(1, 16'hC3D4);
    spi_word(1, 3, 16, 1'b0, 16, 32'hBEEF, rxb);
    cs_high(1);
    chk("m3_miso_word1", rxa, 32'hA1B2);
    chk("m3_miso_word2", rxb, 32'hC3D4);
    chk("m3_dv_count", dv_cnt[1], 32'd2);
    chk("m3_no_underrun", un_cnt[1] - un_s, 32'd0);
    while (exp_q.size() > 0) begin
      if (rxq1.size() == 0) begin
        chk("m3_rx_missing", 32'd0, {16'd0, exp_q.pop_front()});
      end else begin
        chk("m3_rx_order", {16'd0, rxq1.pop_front()}, {16'd0, exp_q.pop_front()});
      end
    end

    // TX valid landing on the word-start cycle (CS_n fall detected two flops later).
    un_s = un_cnt[0]; ready_low0 = 0; watch_ready0 = 1'b1;
    @(negedge clk);
    csn[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 tx_valid[0] = 1'b1; tx_word0 = 8'h5C;
    @(posedge clk);
    #1 tx_valid[0] = 1'b0;
    #(HALF);
    spi_word(0, 0, 8, 1'b1, 8, 32'h81, rxa);
    cs_high(0);
    watch_ready0 = 1'b0;
    chk("ws_miso_word", rxa, 32'h5C);
    chk("ws_no_underrun", un_cnt[0] - un_s, 32'd0);
    chk("ws_ready_never_low", ready_low0, 32'd0);
    chk("ws_rx_word", {24'd0, rxw0}, 32'h81);

    // Mode 1: reset mid-word, then a fresh frame.
    tx_load(2, 16'h0033);
    cs_low(2);
    spi_word(2, 1, 8, 1'b1, 3, 32'hE7, rxa);
    dv_s = dv_cnt[2]; ab_s = ab_cnt[2];
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mr_rst_ready", {31'd0, rdy2}, 32'd1);
    chk("mr_rst_busy", {31'd0, busy2}, 32'd0);
    chk("mr_rst_miso_en", {31'd0, en2}, 32'd0);
    chk("mr_rst_miso", {31'd0, miso2}, 32'd0);
    chk("mr_rst_rx_word0", {24'd0, rxw0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mr_abandoned_busy", {31'd0, busy2}, 32'd0);
    cs_high(2);
    chk("mr_no_dv", dv_cnt[2] - dv_s, 32'd0);
    chk("mr_no_abort", ab_cnt[2] - ab_s, 32'd0);
    cs_low(2);
    spi_word(2, 1, 8, 1'b1, 8, 32'h5A, rxa);
    cs_high(2);
    chk("mr_dv_after", dv_cnt[2] - dv_s, 32'd1);
    chk("mr_rx_word", {24'd0, rxw2}, 32'h5A);
    chk("mr_miso_zero", rxa, 32'h00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
